// File: rtl/sr_ctrl_pkg.sv
// Shared SR op encodings and counter sizing for the SR flag arbiter.
package sr_ctrl_pkg;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  localparam int ILL_CNT_W = 8;
  localparam logic [ILL_CNT_W-1:0] ILL_CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first valid requester at or after rr_ptr, scanning
// upward modulo NREQ, receives a one-hot grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any_grant
);

  int cand;

  // The scan runs from the farthest offset down to rr_ptr, so the nearest
  // valid requester is written last and wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (int'(rr_ptr) + i) % NREQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        winner      = PW'(cand);
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flags. Define SR_FLAG_TOGGLE_EN to make
// op 11 toggle the indexed flag instead of being flagged as illegal.
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = $clog2(NFLAGS),
  parameter int GW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAGS-1:0]    flags_q,
  output logic [NFLAGS-1:0]    flags_qbar,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 err_illegal,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  logic [NREQ-1:0]      arb_grant;
  logic [GW-1:0]        arb_winner;
  logic                 arb_any;
  logic                 accept;
  logic [1:0]           win_op;
  logic [IDXW-1:0]      win_idx;
  logic                 idx_ok;

  logic [NFLAGS-1:0]    flags_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [GW-1:0]        grant_id_q, grant_id_d;
  logic                 err_illegal_q, err_illegal_d;
  logic [ILL_CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  rr_arbiter #(.NREQ(NREQ), .PW(GW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .winner    (arb_winner),
    .any_grant (arb_any)
  );

  // Grants are suppressed while in reset so nothing pending is taken.
  assign req_ready = rst_n ? arb_grant : '0;
  assign accept    = rst_n & arb_any;
  assign win_op    = req_op[2*arb_winner +: 2];
  assign win_idx   = req_idx[IDXW*arb_winner +: IDXW];
  assign idx_ok    = int'(win_idx) < NFLAGS;

  always_comb begin
    flags_d       = flags_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = accept;
    grant_id_d    = grant_id_q;
    err_illegal_d = 1'b0;
    illegal_cnt_d = illegal_cnt_q;
    if (accept) begin
      rr_ptr_d   = (arb_winner == GW'(NREQ - 1)) ? '0 : arb_winner + 1'b1;
      grant_id_d = arb_winner;
      if (idx_ok) begin
        case (win_op)
          SR_CLR:  flags_d[win_idx] = 1'b0;
          SR_SET:  flags_d[win_idx] = 1'b1;
`ifdef SR_FLAG_TOGGLE_EN
          SR_ILL:  flags_d[win_idx] = ~flags_q[win_idx];
`endif
          default: ;
        endcase
      end
`ifndef SR_FLAG_TOGGLE_EN
      if (win_op == SR_ILL) begin
        err_illegal_d = 1'b1;
        if (illegal_cnt_q != ILL_CNT_MAX)
          illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      err_illegal_q <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      flags_q       <= flags_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      err_illegal_q <= err_illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign flags_qbar  = ~flags_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign err_illegal = err_illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
